// File: rtl/dec_sweep_capture.sv
// Sweep-and-capture stage for a combinational decoder: steps every input code,
// samples X after a settle window and publishes the truth table with its popcount.
module dec_sweep_capture #(
  parameter int A_WIDTH       = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    x_in,
  output logic [A_WIDTH-1:0]      a_out,
  output logic                    busy,
  output logic                    done,
  output logic [(1<<A_WIDTH)-1:0] truth_table,
  output logic [A_WIDTH:0]        ones_count
);

  localparam int                 N          = 1 << A_WIDTH;
  localparam int                 OW         = A_WIDTH + 1;
  localparam logic [3:0]         SETTLE_MAX = 4'(SETTLE_CYCLES);
  localparam logic [A_WIDTH-1:0] LAST_CODE  = A_WIDTH'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state, w_state_next;
  logic [A_WIDTH-1:0] r_code, w_code_next;
  logic [3:0]         r_settle, w_settle_next;
  logic [N-1:0]       r_table, w_table_next;
  logic [A_WIDTH:0]   r_ones, w_ones_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_code   <= '0;
      r_settle <= '0;
      r_table  <= '0;
      r_ones   <= '0;
    end else begin
      r_state  <= w_state_next;
      r_code   <= w_code_next;
      r_settle <= w_settle_next;
      r_table  <= w_table_next;
      r_ones   <= w_ones_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_code_next   = r_code;
    w_settle_next = r_settle;
    w_table_next  = r_table;
    w_ones_next   = r_ones;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next  = S_RUN;
          w_code_next   = '0;
          w_settle_next = '0;
          w_table_next  = '0;
          w_ones_next   = '0;
        end
      end
      S_RUN: begin
        // The settle counter never exceeds SETTLE_MAX, so inequality means "still settling".
        if (r_settle != SETTLE_MAX) begin
          w_settle_next = r_settle + 4'd1;
        end else begin
          w_settle_next         = '0;
          w_table_next[r_code]  = x_in;
          w_ones_next           = r_ones + OW'(x_in);
          if (r_code == LAST_CODE) begin
            w_code_next  = '0;
            w_state_next = S_DONE;
          end else begin
            w_code_next = r_code + A_WIDTH'(1);
          end
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign a_out       = r_code;
  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign truth_table = r_table;
  assign ones_count  = r_ones;

endmodule

// File: tb/tb_dec_sweep_capture.sv
// Scoreboard bench: three sweepers with settle windows 2, 0 and 1 driven by
// modelled decoders; expected results are queued at start and checked on done.
module tb_dec_sweep_capture;

  typedef struct packed {
    logic [15:0] tt;
    logic [4:0]  ones;
    logic [31:0] dcyc;
  } exp_t;

  logic        clk = 1'b0;
  logic [31:0] cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  logic        rst   [3];
  logic        start [3];
  logic        x_in  [3];
  logic        x_reg [3];
  logic        busy  [3];
  logic        done  [3];
  logic [3:0]  a_out [3];
  logic [15:0] tt    [3];
  logic [4:0]  ones  [3];
  logic [15:0] func  [3];
  logic        dly   [3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int settle(input int i);
    case (i)
      0: return 2;
      1: return 0;
      default: return 1;
    endcase
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    // Decoder model: X is the selected function of the code, optionally registered once.
    assign x_in[gi] = dly[gi] ? x_reg[gi] : func[gi][a_out[gi]];
    always @(posedge clk) x_reg[gi] <= func[gi][a_out[gi]];

    dec_sweep_capture #(
      .A_WIDTH      (4),
      .SETTLE_CYCLES(settle(gi))
    ) u_dut (
      .clk        (clk),
      .rst        (rst[gi]),
      .start      (start[gi]),
      .x_in       (x_in[gi]),
      .a_out      (a_out[gi]),
      .busy       (busy[gi]),
      .done       (done[gi]),
      .truth_table(tt[gi]),
      .ones_count (ones[gi])
    );
  end

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d cyc=%0d: got %0h, expected %0h", name, i, cyc, act, exp);
    end
  endtask

  function automatic int qsize(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qpop(input int i);
    case (i)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void qpush(input int i, input exp_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  // Reference: a sweep accepted at edge E0 reports func as its table, its popcount,
  // and raises done in the cycle after edge E0 + 16*(settle+1).
  function automatic exp_t model(input int i, input logic [15:0] f, input logic [31:0] e0);
    exp_t e;
    e.tt   = f;
    e.ones = 5'($countones(f));
    e.dcyc = e0 + 32'(16 * (settle(i) + 1));
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done[i] === 1'b1) begin
        if (qsize(i) == 0) begin
          chk("unexpected_done", i, 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = qpop(i);
          chk("truth_table", i, 32'(tt[i]), 32'(e.tt));
          chk("ones_count", i, 32'(ones[i]), 32'(e.ones));
          chk("done_cycle", i, cyc, e.dcyc);
          chk("busy_at_done", i, 32'(busy[i]), 32'd0);
        end
      end
    end
  end

  // Called at a negedge while the instance is idle; the next edge accepts start.
  task automatic start_sweep(input int i, input logic [15:0] f, input logic d);
    func[i]  = f;
    dly[i]   = d;
    start[i] = 1'b1;
    qpush(i, model(i, f, cyc + 1));
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int k = 0;
    while (done[i] !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (done[i] !== 1'b1) chk("done_timeout", i, 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic pulse_start(input int i, input int gap);
    repeat (gap) @(negedge clk);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; func[i] = '0; dly[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_a_out", i, 32'(a_out[i]), 32'd0);
      chk("rst_busy", i, 32'(busy[i]), 32'd0);
      chk("rst_done", i, 32'(done[i]), 32'd0);
      chk("rst_tt", i, 32'(tt[i]), 32'd0);
      chk("rst_ones", i, 32'(ones[i]), 32'd0);
      rst[i] = 1'b0;
    end
    @(negedge clk);

    // X = (A == 6), default settle: check every code's hold time.
    start_sweep(0, 16'h0040, 1'b0);
    for (int t = 0; t < 48; t++) begin
      chk("sweep_a_out", 0, 32'(a_out[0]), 32'(t / 3));
      chk("sweep_busy", 0, 32'(busy[0]), 32'd1);
      @(negedge clk);
    end
    wait_done(0, 10);
    chk("idle_busy", 0, 32'(busy[0]), 32'd0);
    chk("idle_hold_tt", 0, 32'(tt[0]), 32'h0040);
    chk("idle_hold_ones", 0, 32'(ones[0]), 32'd1);

    // x_in tied high, zero settle.
    start_sweep(1, 16'hFFFF, 1'b0);
    wait_done(1, 40);

    // X = A[3]&A[0] with starts re-pulsed mid-sweep.
    start_sweep(0, 16'hAA00, 1'b0);
    pulse_start(0, 3);
    pulse_start(0, 24);
    wait_done(0, 60);

    // Reset in the middle of a sweep: no done, everything cleared.
    start_sweep(0, 16'h00FF, 1'b0);
    repeat (19) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("midrst_a_out", 0, 32'(a_out[0]), 32'd0);
    chk("midrst_busy", 0, 32'(busy[0]), 32'd0);
    chk("midrst_done", 0, 32'(done[0]), 32'd0);
    chk("midrst_tt", 0, 32'(tt[0]), 32'd0);
    chk("midrst_ones", 0, 32'(ones[0]), 32'd0);
    rst[0] = 1'b0;
    void'(qpop(0));
    repeat (60) @(negedge clk);
    start_sweep(0, 16'h00FF, 1'b0);
    wait_done(0, 60);

    // Registered decoder output with one settle cycle.
    start_sweep(2, 16'h8000, 1'b1);
    wait_done(2, 40);

    // start held for 200 cycles: a new sweep is accepted every 50 edges.
    begin
      logic [31:0] c0;
      int k;
      func[0]  = 16'h0001;
      dly[0]   = 1'b0;
      c0       = cyc;
      start[0] = 1'b1;
      for (int n = 0; n * 50 < 200; n++) qpush(0, model(0, 16'h0001, c0 + 1 + 32'(n * 50)));
      repeat (200) @(negedge clk);
      start[0] = 1'b0;
      k = 0;
      while (qsize(0) != 0 && k < 100) begin
        @(negedge clk);
        k++;
      end
      chk("held_start_drained", 0, 32'(qsize(0)), 32'd0);
      repeat (2) @(negedge clk);
    end

    // Randomized sweeps, random decoder functions, optional stray starts.
    for (int r = 0; r < 10; r++) begin
      int i;
      logic d;
      i = $urandom_range(0, 2);
      d = (settle(i) > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      start_sweep(i, 16'($urandom), d);
      if ($urandom_range(0, 1) == 1) pulse_start(i, $urandom_range(1, 10));
      wait_done(i, 80);
    end

    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) chk("queue_empty", i, 32'(qsize(i)), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
